modelado_seq: RTL and testbench

- Sample sequencer for the Modelado datapath (x, w in / y out, 32-bit).
- Walks a sample memory holding up to DEPTH 32-bit words (default 400).
- Drives each word onto the datapath x input and holds w at a latched configuration value.
- Waits a fixed settle latency, captures y, and presents each result on a valid/ready stream to a downstream consumer with backpressure.
- Sits between the sample RAM and the Modelado instance. Replaces bench-side file replay in the system build.

---
 rtl/modelado_seq.sv | 142 ++++++++++++++
 tb/tb_modelado_seq.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modelado_seq.sv
// Sample sequencer: walks the sample memory, drives the Modelado datapath and streams each captured y.
// Define MODELADO_SEQ_CHECKSUM_EN to add a rotate-XOR checksum output over the accepted results.
module modelado_seq #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 400,
  parameter int ADDR_W = 9,
  parameter int DP_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   n_samples,
  input  logic [DATA_W-1:0] w_cfg,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] dp_x,
  output logic [DATA_W-1:0] dp_w,
  input  logic [DATA_W-1:0] dp_y,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [ADDR_W-1:0] res_index,
  output logic              busy,
  output logic              done
`ifdef MODELADO_SEQ_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam int CNT_W = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;
  localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(DP_LAT - 1);
  localparam logic [ADDR_W:0]  DEPTH_C     = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LOAD,
    S_SETTLE,
    S_EMIT,
    S_FIN
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W:0]   count;
  logic [CNT_W-1:0]  settle_cnt;
  logic              run_abort;
  logic              handshake;
  logic              last_sample;

  function automatic logic [ADDR_W:0] clamp_count(input logic [ADDR_W:0] n);
    return (n > DEPTH_C) ? DEPTH_C : n;
  endfunction

  // Abort only matters while a run is in flight; FIN already heads back to IDLE.
  assign run_abort   = abort && (state != S_IDLE) && (state != S_FIN);
  assign handshake   = (state == S_EMIT) && res_valid && res_ready && !run_abort;
  assign last_sample = (({1'b0, idx} + (ADDR_W + 1)'(1)) == count);
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_FIN);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = (clamp_count(n_samples) == '0) ? S_FIN : S_READ;
      S_READ:   state_nxt = S_LOAD;
      S_LOAD:   state_nxt = S_SETTLE;
      S_SETTLE: if (settle_cnt == '0) state_nxt = S_EMIT;
      S_EMIT:   if (handshake) state_nxt = last_sample ? S_FIN : S_READ;
      S_FIN:    state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    if (run_abort) state_nxt = S_FIN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr   <= '0;
      dp_x       <= '0;
      dp_w       <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_index  <= '0;
      idx        <= '0;
      count      <= '0;
      settle_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            count <= clamp_count(n_samples);
            dp_w  <= w_cfg;
            idx   <= '0;
          end
        end
        S_READ: mem_addr <= idx;
        S_LOAD: begin
          dp_x       <= mem_rdata;
          settle_cnt <= SETTLE_INIT;
        end
        S_SETTLE: begin
          if (settle_cnt != '0) begin
            settle_cnt <= settle_cnt - CNT_W'(1);
          end else if (!run_abort) begin
            res_data  <= dp_y;
            res_index <= idx;
            res_valid <= 1'b1;
          end
        end
        S_EMIT: begin
          if (handshake) begin
            res_valid <= 1'b0;
            idx       <= idx + ADDR_W'(1);
          end
        end
        default: ;
      endcase
      // A pending result is dropped on abort, even if the consumer accepts it this cycle.
      if (run_abort) res_valid <= 1'b0;
    end
  end

`ifdef MODELADO_SEQ_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      checksum <= '0;
    end else if ((state == S_IDLE) && start) begin
      checksum <= '0;
    end else if (handshake) begin
      checksum <= {checksum[DATA_W-2:0], checksum[DATA_W-1]} ^ res_data;
    end
  end
`endif

endmodule

// File: tb/tb_modelado_seq.sv
// Bench for modelado_seq: memory and datapath (y = x + 1) modelled in the bench, results checked per scenario.
`timescale 1ns/1ps
module tb_modelado_seq;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 400;
  localparam int ADDR_W = 9;
  localparam int DP_LAT = 2;
  localparam int FIRST  = DP_LAT + 2;
  localparam int PERIOD = DP_LAT + 3;

  logic              clk = 1'b0;
  logic              rst, start, abort, res_ready;
  logic [ADDR_W:0]   n_samples;
  logic [DATA_W-1:0] w_cfg;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata, dp_x, dp_w, dp_y, res_data;
  logic              res_valid, busy, done;
  logic [ADDR_W-1:0] res_index;
`ifdef MODELADO_SEQ_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif

  logic [DATA_W-1:0] mem [DEPTH];

  assign mem_rdata = mem[mem_addr];
  assign dp_y      = dp_x + 32'd1;

  always #5 clk = ~clk;

  modelado_seq #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DP_LAT(DP_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .n_samples(n_samples), .w_cfg(w_cfg),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .dp_x(dp_x), .dp_w(dp_w), .dp_y(dp_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_index(res_index),
    .busy(busy), .done(done)
`ifdef MODELADO_SEQ_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  int n_cmp = 0;
  int n_fail = 0;

  int                got_idx[$];
  logic [DATA_W-1:0] got_data[$];
  int                got_e[$];
  int                done_e[$];
  int                busy_cnt, valid_cnt, hold_bad, dpw_bad, abort_e;
  int                after_busy, after_done, valid_at_done;
  bit                timed_out;

  function automatic void fill_mem(input bit rnd);
    for (int i = 0; i < DEPTH; i++) mem[i] = rnd ? $urandom : 32'(3 * i);
  endfunction

  function automatic logic [DATA_W-1:0] model_cs(input int nres);
    logic [DATA_W-1:0] cs;
    cs = '0;
    for (int k = 0; k < nres; k++) cs = {cs[DATA_W-2:0], cs[DATA_W-1]} ^ (mem[k] + 32'd1);
    return cs;
  endfunction

  // Observation e is taken at the falling edge after rising edge e; edge 0 samples start.
  task automatic do_run(input int n, input logic [DATA_W-1:0] w, input int stall_idx, input int stall_n,
                        input int abort_idx, input int ready_pct, input bit poke);
    int stall_left;
    bit hold, fin;
    logic [DATA_W-1:0] pd;
    logic [ADDR_W-1:0] pi;
    got_idx.delete(); got_data.delete(); got_e.delete(); done_e.delete();
    busy_cnt = 0; valid_cnt = 0; hold_bad = 0; dpw_bad = 0; abort_e = -1;
    after_busy = -1; after_done = -1; valid_at_done = -1; timed_out = 0;
    stall_left = stall_n; hold = 0; fin = 0; pd = '0; pi = '0;
    @(negedge clk);
    start = 1'b1; n_samples = (ADDR_W + 1)'(n); w_cfg = w; res_ready = 1'b1; abort = 1'b0;
    for (int e = 0; e < 4000 && !fin; e++) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      if (poke && e == 1) begin start = 1'b1; n_samples = 10'd3; w_cfg = ~w; end
      if (busy) busy_cnt++;
      if (res_valid) valid_cnt++;
      if (dp_w !== w) dpw_bad++;
      if (hold && (res_valid !== 1'b1 || res_data !== pd || res_index !== pi)) hold_bad++;
      if (done) begin
        done_e.push_back(e);
        valid_at_done = int'(res_valid);
        fin = 1;
        if (poke) start = 1'b1;
      end else begin
        res_ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < ready_pct);
        if (res_valid && int'(res_index) == stall_idx && stall_left > 0) begin
          res_ready = 1'b0; stall_left--;
        end
        if (res_valid && int'(res_index) == abort_idx) begin abort = 1'b1; abort_e = e; end
        if (res_valid && res_ready && !abort) begin
          got_idx.push_back(int'(res_index)); got_data.push_back(res_data); got_e.push_back(e);
        end
        hold = res_valid && !res_ready && !abort; pd = res_data; pi = res_index;
      end
    end
    if (!fin) timed_out = 1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0; res_ready = 1'b1;
    after_busy = int'(busy); after_done = int'(done);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; res_ready = 1'b1; n_samples = '0; w_cfg = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({mem_addr, dp_x, dp_w, res_data, res_index} !== '0) begin
      n_fail++; $display("FAIL reset_data got %h %h %h %h %h want 0", mem_addr, dp_x, dp_w, res_data, res_index);
    end
    n_cmp++;
    if ({res_valid, busy, done} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl got valid/busy/done=%b want 000", {res_valid, busy, done});
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int done_at;
    fill_mem(0);
    do_run(4, 32'h1234_5678, -1, 0, -1, 100, 0);
    done_at = (done_e.size() > 0) ? done_e[0] : -1;
    n_cmp++;
    if (got_idx.size() !== 4) begin n_fail++; $display("FAIL basic_count got %0d want 4", got_idx.size()); end
    for (int k = 0; k < got_idx.size() && k < 4; k++) begin
      n_cmp++;
      if (got_idx[k] !== k || got_data[k] !== mem[k] + 32'd1) begin
        n_fail++; $display("FAIL basic_res%0d got idx %0d data %0d want idx %0d data %0d", k, got_idx[k], got_data[k], k, mem[k] + 32'd1);
      end
      n_cmp++;
      if (got_e[k] !== FIRST + k * PERIOD) begin
        n_fail++; $display("FAIL basic_timing%0d got cycle %0d want %0d", k, got_e[k], FIRST + k * PERIOD);
      end
    end
    n_cmp++;
    if (got_e.size() == 0 || done_at !== got_e[got_e.size()-1] + 1) begin
      n_fail++; $display("FAIL basic_done got cycle %0d want one after last handshake", done_at);
    end
    n_cmp++;
    if (after_busy !== 0 || after_done !== 0 || busy_cnt !== done_at + 1) begin
      n_fail++; $display("FAIL basic_busy got after_busy %0d after_done %0d busy_cycles %0d want 0 0 %0d", after_busy, after_done, busy_cnt, done_at + 1);
    end
    n_cmp++;
    if (dpw_bad !== 0) begin n_fail++; $display("FAIL basic_dp_w got %0d bad cycles want 0", dpw_bad); end
`ifdef MODELADO_SEQ_CHECKSUM_EN
    n_cmp++;
    if (checksum !== model_cs(4)) begin n_fail++; $display("FAIL basic_checksum got %h want %h", checksum, model_cs(4)); end
`endif
  endtask

  task automatic test_backpressure();
    int bad;
    fill_mem(0);
    do_run(4, 32'h0000_0011, 1, 3, -1, 100, 0);
    bad = 0;
    for (int k = 0; k < got_idx.size(); k++) if (got_idx[k] !== k || got_data[k] !== mem[k] + 32'd1) bad++;
    n_cmp++;
    if (got_idx.size() !== 4 || bad !== 0) begin
      n_fail++; $display("FAIL bp_sequence got %0d results %0d wrong want 4 results 0 wrong", got_idx.size(), bad);
    end
    n_cmp++;
    if (hold_bad !== 0 || valid_cnt !== 4 + 3) begin
      n_fail++; $display("FAIL bp_hold got unstable %0d valid_cycles %0d want 0 and 7", hold_bad, valid_cnt);
    end
    n_cmp++;
    if (got_e.size() < 3 || got_e[1] !== FIRST + PERIOD + 3 || got_e[2] !== got_e[1] + PERIOD) begin
      n_fail++; $display("FAIL bp_timing got cycles %p want index1 at %0d", got_e, FIRST + PERIOD + 3);
    end
  endtask

  task automatic test_zero_clamp();
    int bad;
    do_run(0, 32'h0000_0022, -1, 0, -1, 100, 0);
    n_cmp++;
    if (done_e.size() !== 1 || done_e[0] !== 0 || busy_cnt !== 1 || valid_cnt !== 0 || after_busy !== 0) begin
      n_fail++; $display("FAIL zero_run got done_cycles %p busy %0d valid %0d after_busy %0d want [0] 1 0 0", done_e, busy_cnt, valid_cnt, after_busy);
    end
    fill_mem(1);
    do_run(500, 32'h0000_0033, -1, 0, -1, 100, 0);
    bad = 0;
    for (int k = 0; k < got_idx.size(); k++) if (got_idx[k] !== k || got_data[k] !== mem[k] + 32'd1) bad++;
    n_cmp++;
    if (got_idx.size() !== DEPTH || bad !== 0) begin
      n_fail++; $display("FAIL clamp_count got %0d results %0d wrong want %0d results 0 wrong", got_idx.size(), bad, DEPTH);
    end
    n_cmp++;
    if (got_idx.size() == 0 || got_idx[got_idx.size()-1] !== DEPTH - 1 || timed_out) begin
      n_fail++; $display("FAIL clamp_last got last index %0d timeout %0d want %0d", (got_idx.size() > 0) ? got_idx[got_idx.size()-1] : -1, timed_out, DEPTH - 1);
    end
  endtask

  task automatic test_abort();
    fill_mem(0);
    do_run(6, 32'h0000_0044, -1, 0, 2, 100, 0);
    n_cmp++;
    if (got_idx.size() !== 2 || (got_idx.size() == 2 && (got_idx[0] !== 0 || got_idx[1] !== 1))) begin
      n_fail++; $display("FAIL abort_delivered got %p want [0,1]", got_idx);
    end
    n_cmp++;
    if (abort_e !== FIRST + 2 * PERIOD || done_e.size() !== 1 || done_e[0] !== abort_e + 1 || valid_at_done !== 0 || after_done !== 0) begin
      n_fail++; $display("FAIL abort_done got abort_cycle %0d done %p valid_at_done %0d after_done %0d", abort_e, done_e, valid_at_done, after_done);
    end
  endtask

  task automatic test_reset_restart();
    int late_done, late_busy;
    fill_mem(1);
    mem[0] = 32'hCAFE_0001;
    @(negedge clk);
    start = 1'b1; n_samples = 10'd4; w_cfg = 32'hA5A5_0001; res_ready = 1'b1;
    repeat (3) begin @(negedge clk); start = 1'b0; end
    n_cmp++;
    if (dp_x !== 32'hCAFE_0001 || dp_w !== 32'hA5A5_0001) begin
      n_fail++; $display("FAIL rst_pre got dp_x %h dp_w %h want cafe0001 a5a50001", dp_x, dp_w);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({mem_addr, dp_x, dp_w, res_data, res_index, res_valid, busy, done} !== '0) begin
      n_fail++; $display("FAIL rst_mid got dp_x %h dp_w %h valid %b busy %b done %b want all 0", dp_x, dp_w, res_valid, busy, done);
    end
    late_done = 0; late_busy = 0;
    repeat (8) begin @(negedge clk); if (done) late_done++; if (busy) late_busy++; end
    n_cmp++;
    if (late_done !== 0 || late_busy !== 0) begin
      n_fail++; $display("FAIL rst_quiet got done %0d busy %0d cycles want 0 0", late_done, late_busy);
    end
    do_run(2, 32'h0000_0005, -1, 0, -1, 100, 0);
    n_cmp++;
    if (dpw_bad !== 0 || got_idx.size() !== 2 || (got_data.size() == 2 && got_data[1] !== mem[1] + 32'd1)) begin
      n_fail++; $display("FAIL restart got dp_w bad %0d results %0d want 0 bad 2 results", dpw_bad, got_idx.size());
    end
  endtask

  task automatic test_random();
    int n, bad, exp_n;
    logic [DATA_W-1:0] w;
    for (int it = 0; it < 6; it++) begin
      fill_mem(1);
      n = $urandom_range(1, 10);
      w = $urandom;
      exp_n = (n > DEPTH) ? DEPTH : n;
      do_run(n, w, -1, 0, -1, 60, it == 2);
      bad = 0;
      for (int k = 0; k < got_idx.size(); k++) if (got_idx[k] !== k || got_data[k] !== mem[k] + 32'd1) bad++;
      n_cmp++;
      if (got_idx.size() !== exp_n || bad !== 0 || timed_out) begin
        n_fail++; $display("FAIL rand%0d_seq got %0d results %0d wrong timeout %0d want %0d", it, got_idx.size(), bad, timed_out, exp_n);
      end
      n_cmp++;
      if (got_e.size() == 0 || done_e.size() !== 1 || done_e[0] !== got_e[got_e.size()-1] + 1 || after_busy !== 0 || after_done !== 0) begin
        n_fail++; $display("FAIL rand%0d_done got done %p after_busy %0d after_done %0d", it, done_e, after_busy, after_done);
      end
      n_cmp++;
      if (hold_bad !== 0 || dpw_bad !== 0) begin
        n_fail++; $display("FAIL rand%0d_stable got unstable %0d dp_w bad %0d want 0 0", it, hold_bad, dpw_bad);
      end
`ifdef MODELADO_SEQ_CHECKSUM_EN
      n_cmp++;
      if (checksum !== model_cs(exp_n)) begin
        n_fail++; $display("FAIL rand%0d_checksum got %h want %h", it, checksum, model_cs(exp_n));
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_clamp();
    test_abort();
    test_reset_restart();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
